// File: rtl/audio_player.sv
// audio_player: JTAG-controlled sample RAM player emitting one 16-bit sample every SAMPLE_DIV clocks.
module audio_player #(
  parameter int DR_LENGTH  = 32,
  parameter int ADDR_BITS  = 16,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DR_LENGTH-1:0] flags_in,
  input  logic [DR_LENGTH-1:0] adur_in,
  output logic [DR_LENGTH-1:0] aaddr_out,
  output logic                 ram_en,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [15:0]          ram_rdata,
  output logic [15:0]          sample_out,
  output logic                 sample_valid,
  output logic                 playing
);
  localparam int DW = $clog2(SAMPLE_DIV);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT_DATA, HOLD} state_t;
  state_t r_state, w_next;
  logic r_play_s1, r_play_s2, r_play_prev, r_loop_s1, r_loop_s2, r_vld, r_armed;
  logic [ADDR_BITS-1:0] r_addr, r_dur, r_aaddr;
  logic [DW-1:0] r_div;
  logic w_start, w_tc, w_last, w_unused;
  // r_armed blocks a play level that was already high across reset from looking like a rising edge
  assign w_start = r_play_s2 & ~r_play_prev & r_armed & |adur_in[ADDR_BITS-1:0];
  assign w_tc = r_div == DW'(SAMPLE_DIV - 1);
  assign w_last = r_addr == r_dur - 1'b1;
  assign ram_en = r_state == FETCH;
  assign ram_addr = r_addr;
  assign playing = r_state != IDLE;
  assign w_unused = ^{flags_in[DR_LENGTH-1:2], adur_in[DR_LENGTH-1:ADDR_BITS]};
  always_comb begin
    aaddr_out = '0;
    aaddr_out[ADDR_BITS-1:0] = r_aaddr;
    aaddr_out[DR_LENGTH-1] = playing;
  end
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:      w_next = w_start ? FETCH : IDLE;
      FETCH:     w_next = WAIT_DATA;
      WAIT_DATA: w_next = HOLD;
      HOLD:      w_next = !w_tc ? HOLD : (w_last && !r_loop_s2) ? IDLE : FETCH;
      default:   w_next = IDLE;
    endcase
    if (r_state != IDLE && !r_play_s2) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      {r_play_s1, r_play_s2, r_play_prev, r_loop_s1, r_loop_s2, r_vld, r_armed} <= '0;
      r_addr <= '0;
      r_dur <= '0;
      r_aaddr <= '0;
      r_div <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
    end else begin
      r_play_s1 <= flags_in[0];
      r_play_s2 <= r_play_s1;
      r_play_prev <= r_play_s2;
      r_loop_s1 <= flags_in[1];
      r_loop_s2 <= r_loop_s1;
      r_vld <= 1'b1;
      r_armed <= r_armed | (r_vld & ~r_play_s1);
      r_state <= w_next;
      r_div <= (w_next == FETCH || w_next == IDLE) ? '0 : r_div + 1'b1;
      sample_valid <= r_state == WAIT_DATA && w_next == HOLD;
      if (r_state == IDLE && w_start) begin
        r_dur <= adur_in[ADDR_BITS-1:0];
        r_addr <= '0;
        r_aaddr <= '0;
      end
      if (r_state == HOLD && w_next == FETCH) r_addr <= w_last ? '0 : r_addr + 1'b1;
      if (r_state == WAIT_DATA && w_next == HOLD) begin
        sample_out <= ram_rdata;
        r_aaddr <= r_addr;
      end
      if (r_state != IDLE && w_next == IDLE) sample_out <= '0;
    end
  end
endmodule

// File: tb/tb_audio_player.sv
// tb_audio_player: scoreboard bench; stimulus queues expected fetch addresses and samples, a monitor checks them.
module tb_audio_player;
  localparam int DR = 32, AB = 16, DIV = 8;
  logic clk = 0, reset = 1;
  logic [DR-1:0] flags_in = 0, adur_in = 0, aaddr_out;
  logic ram_en, sample_valid, playing;
  logic [AB-1:0] ram_addr;
  logic [15:0] ram_rdata = 0, sample_out;
  int checks = 0, errors = 0, cyc = 0, run_id = 0, mon_run = -1, last_en = -1;
  logic [AB-1:0] exp_addr[$];
  logic [15:0] exp_samp[$];

  audio_player #(.DR_LENGTH(DR), .ADDR_BITS(AB), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .flags_in(flags_in), .adur_in(adur_in), .aaddr_out(aaddr_out),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata), .sample_out(sample_out),
    .sample_valid(sample_valid), .playing(playing));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_rdata <= ram_en ? ram_addr[15:0] * 16'h0011 : 16'hDEAD;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (ram_en) begin
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_ram_en: got ram_en at addr %h expected none", ram_addr);
      end else chk("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
      if (mon_run == run_id && last_en >= 0) chk("fetch_spacing", cyc - last_en, DIV);
      last_en = cyc;
      mon_run = run_id;
    end
    if (sample_valid) begin
      if (exp_samp.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_sample_valid: got sample %h expected none", sample_out);
      end else chk("sample_out", 32'(sample_out), 32'(exp_samp.pop_front()));
      chk("latency", cyc - last_en, 2);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int dur, input logic lp, input int na, input int ns);
    flags_in = 0;
    cycles(4);
    run_id++;
    for (int i = 0; i < na; i++) exp_addr.push_back(AB'(i % dur));
    for (int i = 0; i < ns; i++) exp_samp.push_back(16'(i % dur) * 16'h0011);
    adur_in = dur;
    flags_in = {30'd0, lp, 1'b1};
  endtask

  task automatic wait_samples(input string n);
    int k;
    for (k = 0; k < 300 && exp_samp.size() != 0; k++) @(negedge clk);
    chk(n, exp_samp.size(), 0);
  endtask

  task automatic wait_done(input string n);
    int k;
    for (k = 0; k < 300 && (exp_samp.size() != 0 || exp_addr.size() != 0 || playing); k++) @(negedge clk);
    chk(n, {exp_samp.size() != 0, exp_addr.size() != 0, playing}, 0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ram_en"}, ram_en, 0);
    chk({n, "_sample_valid"}, sample_valid, 0);
    chk({n, "_playing"}, playing, 0);
    chk({n, "_aaddr_out"}, aaddr_out, 0);
    chk({n, "_sample_out"}, 32'(sample_out), 0);
    chk({n, "_ram_addr"}, 32'(ram_addr), 0);
  endtask

  initial begin
    flags_in = 1;
    adur_in = 4;
    cycles(2);
    chk_zero("reset");
    reset = 0;
    cycles(20);
    chk("no_start_after_reset", playing, 0);
    start(4, 0, 4, 4);
    wait_done("run4_done");
    chk("run4_aaddr", aaddr_out, 32'h3);
    chk("run4_sample_zero", 32'(sample_out), 0);
    cycles(30);
    chk("held_no_retrigger", playing, 0);
    start(4, 0, 4, 4);
    for (int k = 0; k < 20 && !playing; k++) @(negedge clk);
    chk("restart_aaddr_cleared", aaddr_out, 32'h8000_0000);
    wait_done("restart_done");
    chk("restart_aaddr", aaddr_out, 32'h3);
    start(0, 0, 0, 0);
    cycles(20);
    chk("adur0_playing", playing, 0);
    start(3, 1, 5, 5);
    wait_samples("loop_samples");
    flags_in = 0;
    cycles(12);
    chk("loop_abort_playing", playing, 0);
    chk("loop_abort_sample", 32'(sample_out), 0);
    start(4, 0, 3, 3);
    wait_samples("mid_samples");
    chk("mid_in_hold", aaddr_out, 32'h8000_0002);
    reset = 1;
    cycles(1);
    chk_zero("mid_reset");
    cycles(1);
    reset = 0;
    cycles(30);
    chk("mid_no_restart", playing, 0);
    chk("queues_empty", exp_addr.size() + exp_samp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_player.md
AUDIO_PLAYER -- requirements
Module: audio_player

Interface
REQ-001 Parameter DR_LENGTH, default 32, SHALL set the width of the flags_in, adur_in and aaddr_out data-register words.
REQ-002 Parameter ADDR_BITS, default 16, SHALL set the sample RAM address width; DR_LENGTH SHALL be at least ADDR_BITS+1.
REQ-003 Parameter SAMPLE_DIV, default 1134, SHALL set the clk cycles per output sample; legal values are 4 or more.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 flags_in  in  DR_LENGTH  JTAG flags word, asynchronous to clk; bit0 = play, bit1 = loop, other bits ignored.
REQ-008 adur_in  in  DR_LENGTH  sample count, asynchronous; only [ADDR_BITS-1:0] used; sampled only at start.
REQ-009 aaddr_out  out  DR_LENGTH  status word to the JTAG aaddr register: [ADDR_BITS-1:0] = last played address, [DR_LENGTH-1] = playing, other bits 0.
REQ-010 ram_en  out  1  one-cycle sample RAM read strobe.
REQ-011 ram_addr  out  ADDR_BITS  sample RAM read address, valid while ram_en=1.
REQ-012 ram_rdata  in  16  sample RAM read data, valid exactly one cycle after ram_en.
REQ-013 sample_out  out  16  current signed audio sample.
REQ-014 sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-015 playing  out  1  high while not in IDLE.

Function
REQ-016 flags_in[0] and flags_in[1] SHALL each pass through a 2-flop synchronizer; a further register SHALL hold the previous synchronized play value for edge detection.
REQ-017 States: IDLE, FETCH, WAIT_DATA, HOLD.
REQ-018 IDLE: a synchronized play rising edge with adur_in[ADDR_BITS-1:0] != 0 SHALL latch dur from adur_in, clear addr and aaddr_out[ADDR_BITS-1:0] to 0, clear the divider, and go to FETCH.
REQ-019 A play rising edge with dur = 0 SHALL be ignored; the block SHALL stay in IDLE.
REQ-020 FETCH: ram_en=1 and ram_addr=addr for exactly one cycle; the next state SHALL be WAIT_DATA.
REQ-021 WAIT_DATA: ram_rdata SHALL be registered into sample_out, with sample_valid high in the following cycle, so the latency from ram_en to sample_valid is 2 cycles.
REQ-022 WAIT_DATA SHALL also set aaddr_out[ADDR_BITS-1:0] to addr and go to HOLD.
REQ-023 The divider SHALL count 0..SAMPLE_DIV-1 from each FETCH entry; consecutive ram_en pulses SHALL be exactly SAMPLE_DIV cycles apart.
REQ-024 At divider terminal count in HOLD, if addr != dur-1, addr SHALL increment and the state SHALL go to FETCH.
REQ-025 At divider terminal count in HOLD, if addr == dur-1 and loop_sync=1, addr SHALL wrap to 0 and the state SHALL go to FETCH.
REQ-026 At divider terminal count in HOLD, if addr == dur-1 and loop_sync=0, the state SHALL go to IDLE.
REQ-027 A synchronized play value of 0 in any non-IDLE state SHALL force IDLE on the next edge with no further ram_en; this abort SHALL override the divider terminal count in the same cycle.
REQ-028 On any entry to IDLE, sample_out SHALL become 0 and aaddr_out[ADDR_BITS-1:0] SHALL hold its value.
REQ-029 A restart SHALL require play to fall and rise again; play held high after completion SHALL NOT retrigger.
REQ-030 loop_sync SHALL be evaluated only at the terminal count of the last sample; changing loop mid-sequence SHALL affect only the next wrap decision.
REQ-031 dur and addr SHALL be ADDR_BITS wide; dur = 2^ADDR_BITS is not representable (adur 0 means "no play").
REQ-032 aaddr_out[DR_LENGTH-1] SHALL equal playing.

Reset
REQ-033 Reset SHALL force IDLE, all synchronizer and edge flops to 0, and addr, dur and the divider to 0.
REQ-034 Reset SHALL drive aaddr_out, sample_out and ram_addr to 0, and ram_en, sample_valid and playing to 0, on the next edge.
REQ-035 Reset SHALL take priority over all other events, including mid-playback.
REQ-036 After reset, a play level already high SHALL NOT start playback until it has been seen low.

Verification
REQ-037 Hold reset 2 cycles with flags_in=1 -> all outputs 0; no playback after release until play toggles 0->1.
REQ-038 SAMPLE_DIV=8, RAM[a]=a*16'h0011, adur=4, play 0->1 -> sample_out 0000,0011,0022,0033 on sample_valid pulses 8 cycles apart, then playing=0, aaddr_out=4'h3 with MSB 0, sample_out=0.
REQ-039 adur=3, loop=1, play high -> ram_addr 0,1,2,0,1,...; clearing flags_in[0] -> no ram_en later than 4 cycles after the change, playing=0.
REQ-040 adur=0, play 0->1 -> playing stays 0 and ram_en never asserts.
REQ-041 Assert reset during HOLD of sample 2 -> next cycle all outputs 0 and state IDLE; with play still high, no restart.
REQ-042 After a completed run with play held high -> no ram_en; play 1->0->1 -> aaddr_out low bits cleared to 0 and playback restarts at address 0.
